// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display: a 4-character
// scrolling buffer, blanked digit slots, and a one-deep character handshake.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clear,
    input  logic       char_valid,
    input  logic [3:0] char_code,
    output logic       char_ready,
    output logic [3:0] digit_code,
    output logic [3:0] an,
    output logic       scan_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       idx, idx_next;
    logic [3:0][3:0]  data, data_next;
    logic [3:0]       valid, valid_next;
    logic             pending, pending_next;
    logic [3:0]       pend_code, pend_code_next;
    logic [3:0]       an_next, digit_next;
    logic             tick_next, ready_next;
    logic             slot_end, accept, apply;

    function automatic logic [3:0] anode_pattern(input logic [1:0] sel, input logic lit);
        logic [3:0] pat;
        pat = 4'b1111;
        if (lit)
            pat[sel] = 1'b0;
        return pat;
    endfunction

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        idx_next       = idx;
        data_next      = data;
        valid_next     = valid;
        pending_next   = pending;
        pend_code_next = pend_code;

        slot_end = en && (state == DRIVE) && (cnt == CNT_LAST);
        accept   = char_valid && char_ready;
        // With the scan frozen there is no slot boundary to wait for.
        apply    = pending && (slot_end || !en);

        if (en) begin
            case (state)
                BLANK: begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == BLANK_LAST)
                        state_next = DRIVE;
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        idx_next   = idx + 2'd1;
                        state_next = BLANK;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: state_next = BLANK;
            endcase
        end

        if (clear) begin
            data_next    = '0;
            valid_next   = '0;
            pending_next = 1'b0;
        end else if (apply) begin
            data_next    = {data[2:0], pend_code};
            valid_next   = {valid[2:0], 1'b1};
            pending_next = 1'b0;
        end

        // Accepting after the clear orders the clear before the new character.
        if (accept) begin
            pending_next   = 1'b1;
            pend_code_next = char_code;
        end

        ready_next = !pending_next;
        tick_next  = slot_end;
        digit_next = slot_end ? data_next[idx_next] : digit_code;
        an_next    = anode_pattern(idx_next,
                                   en && (state_next == DRIVE) && valid_next[idx_next]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            data       <= '0;
            valid      <= '0;
            pending    <= 1'b0;
            pend_code  <= '0;
            char_ready <= 1'b1;
            digit_code <= '0;
            an         <= 4'b1111;
            scan_tick  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            data       <= data_next;
            valid      <= valid_next;
            pending    <= pending_next;
            pend_code  <= pend_code_next;
            char_ready <= ready_next;
            digit_code <= digit_next;
            an         <= an_next;
            scan_tick  <= tick_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-slot expectations are queued by the
// stimulus and checked by a monitor on every scan slot.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clear;
    logic       char_valid;
    logic [3:0] char_code;
    logic       char_ready;
    logic [3:0] digit_code;
    logic [3:0] an;
    logic       scan_tick;

    typedef struct packed {
        logic [3:0] dc;
        logic [3:0] an;
    } slot_t;

    slot_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  en_d = 1'b1;
    logic  mon_active = 1'b1;

    seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clear      (clear),
        .char_valid (char_valid),
        .char_code  (char_code),
        .char_ready (char_ready),
        .digit_code (digit_code),
        .an         (an),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_d <= en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_slot(input logic [3:0] dc, input logic [3:0] an_v);
        slot_t s;
        s.dc = dc;
        s.an = an_v;
        exp_q.push_back(s);
    endtask

    task automatic next_tick();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!scan_tick && t < 20);
        if (!scan_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no scan_tick expected one within 20 cycles");
        end
    endtask

    task automatic send(input logic [3:0] c);
        char_valid = 1'b1;
        char_code  = c;
        @(negedge clk);
        char_valid = 1'b0;
        char_code  = 4'h0;
    endtask

    // Monitor: pops one expectation per slot and checks an/digit_code every cycle.
    initial begin
        slot_t cur;
        int    pos = 0;
        bit    started = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (mon_active) begin
                if (scan_tick) begin
                    if (started)
                        check("slot_len", pos, 7);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tick: got scan_tick expected no more slots");
                    end else begin
                        cur = exp_q.pop_front();
                        check("digit_code", digit_code, cur.dc);
                    end
                    pos     = 0;
                    started = 1;
                    check("an_blank", an, 4'hF);
                end else if (started) begin
                    if (en_d)
                        pos++;
                    check("digit_hold", digit_code, cur.dc);
                    if (!en_d || pos < 2)
                        check("an_dark", an, 4'hF);
                    else
                        check("an_drive", an, cur.an);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        clear      = 1'b0;
        char_valid = 1'b0;
        char_code  = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_digit", digit_code, 4'h0);
        check("rst_ready", char_ready, 1'b1);
        check("rst_tick", scan_tick, 1'b0);

        // Slots 1..4: empty buffer, then the '5' pushed in slot 0 shows in digit 0.
        push_slot(4'h0, 4'hF);
        push_slot(4'h0, 4'hF);
        push_slot(4'h0, 4'hF);
        push_slot(4'h5, 4'hE);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(4'h5);
        check("ready_drop", char_ready, 1'b0);
        repeat (3) @(negedge clk);
        check("ready_wait", char_ready, 1'b0);
        @(negedge clk);
        check("ready_rise", char_ready, 1'b1);
        check("first_tick", scan_tick, 1'b1);

        // Slot 5: clear together with a new character '7'.
        push_slot(4'h0, 4'hF);
        push_slot(4'h0, 4'hF);
        push_slot(4'h0, 4'hF);
        push_slot(4'h7, 4'hE);
        repeat (4) next_tick();
        clear      = 1'b1;
        char_valid = 1'b1;
        char_code  = 4'h7;
        @(negedge clk);
        clear      = 1'b0;
        char_valid = 1'b0;
        check("ready_after_clear_push", char_ready, 1'b0);

        // Slot 9: clear, then 1,2,3,4 one per slot; slot 16 pushes 9; slot 21 pushes 6.
        push_slot(4'h0, 4'hF);
        push_slot(4'h0, 4'hF);
        push_slot(4'h0, 4'hF);
        push_slot(4'h3, 4'hE);
        push_slot(4'h3, 4'hD);
        push_slot(4'h2, 4'hB);
        push_slot(4'h1, 4'h7);
        push_slot(4'h4, 4'hE);
        push_slot(4'h4, 4'hD);
        push_slot(4'h3, 4'hB);
        push_slot(4'h2, 4'h7);
        push_slot(4'h9, 4'hE);
        push_slot(4'h4, 4'hD);
        push_slot(4'h4, 4'hB);
        push_slot(4'h3, 4'h7);
        push_slot(4'h6, 4'hE);
        push_slot(4'h9, 4'hD);
        repeat (4) next_tick();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("ready_before_1", char_ready, 1'b1);
        send(4'h1);
        check("ready_after_1", char_ready, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            next_tick();
            check("ready_b2b", char_ready, 1'b1);
            send(4'(c));
        end
        repeat (4) next_tick();
        check("ready_before_9", char_ready, 1'b1);
        send(4'h9);

        // Slot 21: pending '6', then freeze the scan mid-DRIVE.
        repeat (5) next_tick();
        send(4'h6);
        check("ready_pending_6", char_ready, 1'b0);
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("ready_en0_apply", char_ready, 1'b1);
        check("an_en0", an, 4'hF);
        repeat (2) @(negedge clk);
        en = 1'b1;

        // Slot 25: asynchronous reset in the middle of the slot.
        repeat (4) next_tick();
        repeat (3) @(negedge clk);
        mon_active = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", an, 4'hF);
        check("async_rst_digit", digit_code, 4'h0);
        check("async_rst_ready", char_ready, 1'b1);
        check("async_rst_tick", scan_tick, 1'b0);
        check("queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("rst_hold_an", an, 4'hF);
        check("rst_hold_tick", scan_tick, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes the 4-digit common-anode 7-segment display on the Morse reader board.
- Holds a 4-character scrolling buffer of decoded 4-bit character codes. Each new character enters at digit 0; older characters shift left.
- Each cycle it presents one digit's code to the BCD-to-segment decoder and drives the active-low anodes.
- Inserts a blanking interval before each digit so segment changes never show on the wrong digit.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 1000: cycles at the start of each slot during which all anodes are off. Must be ≥ 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  display enable; 0 = dark and scan frozen
- clear  input  1  synchronous clear of the buffer
- char_valid  input  1  new character code offered
- char_code  input  4  character code, valid with char_valid
- char_ready  output  1  registered; high when a new character can be accepted
- digit_code  output  4  registered; code for the decoder's 4-bit input
- an  output  4  registered; active-low anodes, an[i]=0 lights digit i
- scan_tick  output  1  registered one-cycle pulse at each slot start

Behaviour:
- Reset (async, rst_n=0): the following values hold until rst_n rises.
  - Outputs: an=4'b1111, digit_code=0, char_ready=1, scan_tick=0.
  - Internal: state=BLANK, idx=0, cnt=0, buffer data=0, valid mask=0, pending=0.
- Handshake:
  - A character is accepted on a cycle with char_valid & char_ready. char_code is captured into a pending register, pending=1, and char_ready=0 from the next cycle.
  - A pending character is applied at the next DRIVE→BLANK transition, or on the next cycle if en=0. Apply means data[3:1]←data[2:0], data[0]←pending code, valid[3:1]←valid[2:0], valid[0]←1. pending then clears and char_ready=1 on the following cycle.
  - char_code is ignored when char_ready=0.
- Scan FSM, counter cnt runs 0..REFRESH_DIV-1:
  - BLANK: an=4'b1111. On entry, digit_code←data[idx] and scan_tick=1 for that one cycle. After BLANK_CYCLES cycles, go to DRIVE.
  - DRIVE: an[idx]=0 if valid[idx], otherwise 4'b1111 (unloaded digits stay dark). Other anodes stay high. When cnt reaches REFRESH_DIV-1, set cnt←0, idx←(idx+1) mod 4 (3 wraps to 0), and go to BLANK.
  - digit_code is constant for the whole slot, so the decoder output settles while dark.
- Exactly one anode may be low at any time; an must never change in the same cycle as digit_code.
- en=0: an=4'b1111 from the next cycle. cnt, idx, state and digit_code hold. When en returns to 1, resume from the held state.
- clear=1:
  - Next cycle: data=0, valid=0, pending=0; scan position is unaffected.
  - Display goes dark (all digits invalid) from the next DRIVE.
  - A char_valid&char_ready in the same cycle is still accepted. It becomes pending against the emptied buffer, so clear is ordered before the new character.
- Full buffer: a fifth character shifts out the character previously in digit 3; there is no overflow flag.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, en=1, no chars:
  - an stays 1111 indefinitely.
  - scan_tick pulses every 8 cycles.
  - digit_code=0.
- Push code 4'h5 at cycle 3:
  - char_ready drops the next cycle.
  - Applied at the next slot boundary (cycle 8); char_ready rises one cycle after.
  - an=1110 during cycles 2..7 of each slot with idx=0; digit_code=5 in that slot.
- Push 1,2,3,4 back-to-back, each on the cycle char_ready is high:
  - Result data[3..0]=1,2,3,4, all valid.
  - an sequence per slot: 1110, 1101, 1011, 0111, then wraps.
  - an=1111 for the first 2 cycles of each slot.
- Push a fifth code 4'h9 after the buffer is full: data[3..0]=2,3,4,9.
- Assert clear with char_valid=1, char_code=7 in the same cycle: buffer ends up with only digit 0 = 7 valid.
- Drop en mid-DRIVE with a pending character:
  - an=1111 next cycle and the character is applied next cycle.
  - Restore en: scan resumes at the same cnt/idx.
  - Assert rst_n=0 mid-slot: outputs return to reset values immediately, independent of clk.
